sha256_msg_schedule_ctrl: RTL and testbench

Sequencer for the SHA-256 message-schedule datapath. It accepts one 512-bit block as 16 words, then streams W[0..63] to the compression round logic over a valid/ready interface. It owns a 16-word circular buffer and uses one small-sigma0 instance and one small-sigma1 instance to expand W[16..63]. It sits between the block padder/loader and the compression core.

---
 rtl/sha256_pkg.sv | 28 ++
 rtl/sha256_small_sigma.sv | 17 +
 rtl/sha256_msg_schedule_ctrl.sv | 121 ++++++++++++
 tb/tb_sha256_msg_schedule_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and word type for the SHA-256 message-schedule sequencer.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int ROUNDS      = 64;

  localparam int CNT_W = 4;  // indexes the 16-word load
  localparam int T_W   = 7;  // must hold ROUNDS itself, not just ROUNDS-1
  localparam int IDX_W = 6;

  // Rotate/shift amounts for the two small-sigma functions.
  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR   = 3;
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR   = 10;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } state_e;

endpackage

// File: rtl/sha256_small_sigma.sv
// Combinational SHA-256 small sigma: rotr(A) ^ rotr(B) ^ shr(S).
module sha256_small_sigma
  import sha256_pkg::*;
#(
  parameter int ROT_A = S0_ROT_A,
  parameter int ROT_B = S0_ROT_B,
  parameter int SHR   = S0_SHR
) (
  input  logic [WORD_W-1:0] x_i,
  output logic [WORD_W-1:0] y_o
);

  assign y_o = ((x_i >> ROT_A) | (x_i << (WORD_W - ROT_A)))
             ^ ((x_i >> ROT_B) | (x_i << (WORD_W - ROT_B)))
             ^ (x_i >> SHR);

endmodule

// File: rtl/sha256_msg_schedule_ctrl.sv
// SHA-256 message-schedule sequencer: loads 16 words into a circular buffer,
// then streams W[0..63] over valid/ready, expanding W[16..63] in place.
module sha256_msg_schedule_ctrl
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WORD_W-1:0] load_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [IDX_W-1:0]  w_index,
  output logic              busy,
  output logic              done
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [T_W-1:0]   t_q;
  logic             w_valid_q;
  word_t            w_data_q;
  logic [IDX_W-1:0] w_index_q;
  logic             done_q;
  word_t            buf_q [BLOCK_WORDS];

  logic [CNT_W-1:0] idx, idx_m2, idx_m7, idx_m15;
  word_t            sig0_w, sig1_w, expand_w, next_w;
  logic             emit, last_accept, load_fire;

  // Buffer slots wrap modulo 16 while t itself runs to 64.
  assign idx     = t_q[CNT_W-1:0];
  assign idx_m2  = idx - CNT_W'(2);
  assign idx_m7  = idx - CNT_W'(7);
  assign idx_m15 = idx - CNT_W'(15);

  sha256_small_sigma #(.ROT_A(S0_ROT_A), .ROT_B(S0_ROT_B), .SHR(S0_SHR)) u_sig0 (
    .x_i (buf_q[idx_m15]),
    .y_o (sig0_w)
  );

  sha256_small_sigma #(.ROT_A(S1_ROT_A), .ROT_B(S1_ROT_B), .SHR(S1_SHR)) u_sig1 (
    .x_i (buf_q[idx_m2]),
    .y_o (sig1_w)
  );

  assign expand_w    = sig1_w + buf_q[idx_m7] + sig0_w + buf_q[idx];
  assign next_w      = (t_q < T_W'(BLOCK_WORDS)) ? buf_q[idx] : expand_w;
  assign load_fire   = (state_q == LOAD) && load_valid;
  assign emit        = (state_q == STREAM) && (!w_valid_q || w_ready) && (t_q < T_W'(ROUNDS));
  assign last_accept = (state_q == STREAM) && w_valid_q && w_ready && (t_q == T_W'(ROUNDS));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      t_q       <= '0;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_index_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            t_q     <= '0;
          end
        end
        LOAD: begin
          if (load_fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BLOCK_WORDS - 1)) begin
              state_q <= STREAM;
              t_q     <= '0;
            end
          end
        end
        STREAM: begin
          if (emit) begin
            w_data_q  <= next_w;
            w_index_q <= t_q[IDX_W-1:0];
            w_valid_q <= 1'b1;
            t_q       <= t_q + T_W'(1);
          end else if (last_accept) begin
            w_valid_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the buffer is deliberately not reset; it is always fully loaded
  // before any slot is read, so a reset would only add clear logic.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_fire) begin
        buf_q[cnt_q] <= load_data;
      end else if (emit && (t_q >= T_W'(BLOCK_WORDS))) begin
        buf_q[idx] <= expand_w;
      end
    end
  end

  assign load_ready = (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign w_valid    = w_valid_q;
  assign w_data     = w_data_q;
  assign w_index    = w_index_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule_ctrl.sv
// Directed bench for sha256_msg_schedule_ctrl against a plain W[0..63] reference model.
module tb_sha256_msg_schedule_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [5:0]  w_index;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] blk_abc  [16];
  logic [31:0] blk_zero [16];
  logic [31:0] blk_pat  [16];
  logic [31:0] blk_rnd  [16];
  logic [31:0] exp_w    [64];

  sha256_msg_schedule_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .w_index    (w_index),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic build_model(input logic [31:0] blk [16]);
    for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  // Starts a block and feeds 16 words; returns the cycle of word 15's handshake.
  task automatic load_block(input logic [31:0] blk [16], input bit gap, input bit noise,
                            output int c15);
    int n = 0;
    int k = 0;
    c15 = -1;
    build_model(blk);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 32'hBAD0_BAD0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_ready_in_load", {31'b0, load_ready}, 32'd1);
    while (n < 16 && k < 200) begin
      if (gap && (k % 2 == 0)) begin
        load_valid = 1'b0;
        load_data  = $urandom;
      end else begin
        load_valid = 1'b1;
        load_data  = blk[n];
      end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (load_valid && load_ready) begin
        if (n == 15) c15 = cyc;
        n++;
      end
      k++;
      if (n < 16) @(negedge clk);
    end
    if (n < 16) check("load_timeout", n, 32'd16);
  endtask

  // mode 0: ready always high, 1: random ready, 2: stall 3 cycles at W[20]
  task automatic run_stream(input int mode, input int c15, input bit noise,
                            input bit abc, input bit start_at_end);
    int  got   = 0;
    int  first = -1;
    int  stall = 0;
    bit  rdy;
    for (int k = 0; k < 2000 && got < 64; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      load_data  = $urandom;
      start      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == 0) check("load_ready_after_load", {31'b0, load_ready}, 32'd0);
      case (mode)
        1:       rdy = 1'($urandom_range(0, 1));
        2:       rdy = !(w_valid && w_index == 6'd20 && stall < 3);
        default: rdy = 1'b1;
      endcase
      w_ready = rdy;
      if (w_valid && first < 0) begin
        first = cyc;
        if (mode == 0) check("first_w_valid_cycle", first, c15 + 2);
      end
      if (mode == 2 && w_valid && !rdy) begin
        stall++;
        check("stall_hold_index", {26'b0, w_index}, 32'd20);
        check("stall_hold_data", w_data, exp_w[20]);
      end
      if (w_valid && rdy) begin
        check("w_index", {26'b0, w_index}, got);
        check("w_data", w_data, exp_w[got]);
        if (abc && got == 16) check("abc_w16_hand", w_data, 32'h6162_6380);
        if (abc && got == 17) check("abc_w17_hand", w_data, 32'h000F_0000);
        if (got == 63) begin
          if (mode == 0) check("w63_cycle", cyc, c15 + 65);
          if (start_at_end) start = 1'b1;
        end
        got++;
      end
    end
    if (got < 64) check("stream_timeout", got, 32'd64);
    if (mode == 2) check("stall_cycles", stall, 32'd3);
    @(negedge clk);
    start   = 1'b0;
    w_ready = 1'b0;
    check("done_pulse", {31'b0, done}, 32'd1);
    check("busy_low_at_done", {31'b0, busy}, 32'd0);
    check("w_valid_low_at_done", {31'b0, w_valid}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("idle_after_done", {30'b0, busy, load_ready}, 32'd0);
  endtask

  task automatic reset_mid_stream(input int c15);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      w_ready    = 1'b1;
      if (w_valid && w_index == 6'd30) seen = 1'b1;
    end
    check("reached_t30", {31'b0, seen}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_w_valid", {31'b0, w_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_load_ready", {31'b0, load_ready}, 32'd0);
    check("rst_w_data", w_data, 32'd0);
    check("rst_w_index", {26'b0, w_index}, 32'd0);
    @(negedge clk);
    w_ready = 1'b0;
    check("rst_stays_idle", {30'b0, busy, w_valid}, 32'd0);
  endtask

  initial begin
    int c15;
    rst        = 1'b1;
    start      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    w_ready    = 1'b0;

    for (int i = 0; i < 16; i++) begin
      blk_abc[i]  = 32'h0;
      blk_zero[i] = 32'h0;
      blk_pat[i]  = (32'h0101_0101 * i) ^ 32'hDEAD_BEEF;
      blk_rnd[i]  = $urandom;
    end
    blk_abc[0]  = 32'h6162_6380;
    blk_abc[15] = 32'h0000_0018;

    repeat (3) @(negedge clk);
    check("reset_load_ready", {31'b0, load_ready}, 32'd0);
    check("reset_w_valid", {31'b0, w_valid}, 32'd0);
    check("reset_w_data", w_data, 32'd0);
    check("reset_w_index", {26'b0, w_index}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    rst = 1'b0;

    load_block(blk_abc, 1'b0, 1'b0, c15);
    run_stream(0, c15, 1'b0, 1'b1, 1'b1);

    load_block(blk_zero, 1'b0, 1'b0, c15);
    run_stream(0, c15, 1'b0, 1'b0, 1'b0);

    load_block(blk_pat, 1'b1, 1'b1, c15);
    run_stream(2, c15, 1'b1, 1'b0, 1'b0);

    load_block(blk_rnd, 1'b0, 1'b1, c15);
    run_stream(1, c15, 1'b1, 1'b0, 1'b0);

    load_block(blk_abc, 1'b0, 1'b0, c15);
    reset_mid_stream(c15);

    load_block(blk_abc, 1'b1, 1'b0, c15);
    run_stream(0, c15, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
